// File: rtl/rv32imc_3p_wb_arb_pkg.sv
// ============================================================================
// rv32imc_3p_pkg : load funct3 encodings and write-back source select
// Rev 1.0
// ============================================================================
`default_nettype none

package rv32imc_3p_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_LD   = 3'd1,
    SRC_HOLD = 3'd2,
    SRC_ALU  = 3'd3,
    SRC_MD   = 3'd4
  } src_e;

endpackage

`default_nettype wire

// File: rtl/rv32imc_3p_wb_arb_if.sv
// ============================================================================
// rv32imc_3p_wb_arb_if : result sources, load tracking and RF write port
// Rev 1.0
// ============================================================================
`default_nettype none

interface rv32imc_3p_wb_arb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_dat;
  logic            ld_req_valid;
  logic [AW-1:0]   ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic            ld_rsp_valid;
  logic [XLEN-1:0] ld_rsp_dat;
  logic            md_valid;
  logic [AW-1:0]   md_rd;
  logic [XLEN-1:0] md_dat;
  logic            md_ack;
  logic            c_rf_write;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_dati;
  logic            stall;
  logic            ld_busy;
  logic [AW-1:0]   ld_pend_rd;

  // Core side: drives the sources, consumes the RF port and interlocks.
  modport master (
    output alu_valid, alu_rd, alu_dat,
    output ld_req_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rsp_valid, ld_rsp_dat,
    output md_valid, md_rd, md_dat,
    input  md_ack, c_rf_write, rd_addr, rd_dati, stall, ld_busy, ld_pend_rd
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_dat,
    input  ld_req_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rsp_valid, ld_rsp_dat,
    input  md_valid, md_rd, md_dat,
    output md_ack, c_rf_write, rd_addr, rd_dati, stall, ld_busy, ld_pend_rd
  );
endinterface

`default_nettype wire

// File: rtl/rv32imc_3p_wb_arb_ld_ext.sv
// ============================================================================
// rv32imc_3p_ld_ext : byte/half extraction and sign/zero extension of a load
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32imc_3p_ld_ext
  import rv32imc_3p_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic [2:0]      funct3,
  input  wire logic [1:0]      addr_lo,
  input  wire logic [XLEN-1:0] word,
  output logic      [XLEN-1:0] dat
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Anything that is not a byte/half form is written back as the full word.
  always_comb begin
    dat = word;
    case (funct3)
      LB:      dat = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     dat = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      dat = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     dat = {{(XLEN-16){1'b0}}, half_sel};
      default: dat = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv32imc_3p_wb_arb.sv
// ============================================================================
// rv32imc_3p_wb_arb : merges load, ALU and mul/div results onto the RF port
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32imc_3p_wb_arb
  import rv32imc_3p_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input wire logic clk,
  input wire logic rst,
  rv32imc_3p_wb_arb_if.slave bus
);

  logic            ld_busy_q,    ld_busy_d;
  logic [AW-1:0]   ld_rd_q,      ld_rd_d;
  logic [2:0]      ld_f3_q,      ld_f3_d;
  logic [1:0]      ld_lo_q,      ld_lo_d;
  logic            hold_valid_q, hold_valid_d;
  logic [AW-1:0]   hold_rd_q,    hold_rd_d;
  logic [XLEN-1:0] hold_dat_q,   hold_dat_d;
  logic            stall_q,      stall_d;
  logic            rf_we_q,      rf_we_d;
  logic [AW-1:0]   rd_addr_q,    rd_addr_d;
  logic [XLEN-1:0] rd_dati_q,    rd_dati_d;

  logic            ld_done;
  logic [XLEN-1:0] ld_ext_dat;
  src_e            sel;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_dat;

  rv32imc_3p_ld_ext #(.XLEN(XLEN)) u_ld_ext (
    .funct3  (ld_f3_q),
    .addr_lo (ld_lo_q),
    .word    (bus.ld_rsp_dat),
    .dat     (ld_ext_dat)
  );

  // A response with nothing outstanding is noise and must not win.
  assign ld_done = bus.ld_rsp_valid && ld_busy_q;

  always_comb begin
    sel     = SRC_NONE;
    win_rd  = '0;
    win_dat = '0;
    if (ld_done) begin
      sel     = SRC_LD;
      win_rd  = ld_rd_q;
      win_dat = ld_ext_dat;
    end else if (hold_valid_q) begin
      sel     = SRC_HOLD;
      win_rd  = hold_rd_q;
      win_dat = hold_dat_q;
    end else if (bus.alu_valid) begin
      sel     = SRC_ALU;
      win_rd  = bus.alu_rd;
      win_dat = bus.alu_dat;
    end else if (bus.md_valid) begin
      sel     = SRC_MD;
      win_rd  = bus.md_rd;
      win_dat = bus.md_dat;
    end
  end

  always_comb begin
    ld_busy_d = ld_busy_q;
    ld_rd_d   = ld_rd_q;
    ld_f3_d   = ld_f3_q;
    ld_lo_d   = ld_lo_q;
    if (bus.ld_req_valid) begin
      ld_busy_d = 1'b1;
      ld_rd_d   = bus.ld_rd;
      ld_f3_d   = bus.ld_funct3;
      ld_lo_d   = bus.ld_addr_lo;
    end else if (ld_done) begin
      ld_busy_d = 1'b0;
    end
  end

  // Stall covers the cycle the hold drains plus one more, so the upstream
  // freeze lines up with its registered view of stall.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_dat_d   = hold_dat_q;
    if (sel == SRC_HOLD) begin
      hold_valid_d = 1'b0;
    end else if (bus.alu_valid && (sel != SRC_ALU) && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = bus.alu_rd;
      hold_dat_d   = bus.alu_dat;
    end
    stall_d = hold_valid_d | hold_valid_q;
  end

  always_comb begin
    rf_we_d   = (sel != SRC_NONE) && (win_rd != '0);
    rd_addr_d = rd_addr_q;
    rd_dati_d = rd_dati_q;
    if (sel != SRC_NONE) begin
      rd_addr_d = win_rd;
      rd_dati_d = win_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_busy_q    <= 1'b0;
      ld_rd_q      <= '0;
      ld_f3_q      <= '0;
      ld_lo_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_dat_q   <= '0;
      stall_q      <= 1'b0;
      rf_we_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_dati_q    <= '0;
    end else begin
      ld_busy_q    <= ld_busy_d;
      ld_rd_q      <= ld_rd_d;
      ld_f3_q      <= ld_f3_d;
      ld_lo_q      <= ld_lo_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_dat_q   <= hold_dat_d;
      stall_q      <= stall_d;
      rf_we_q      <= rf_we_d;
      rd_addr_q    <= rd_addr_d;
      rd_dati_q    <= rd_dati_d;
    end
  end

  assign bus.md_ack     = (sel == SRC_MD);
  assign bus.c_rf_write = rf_we_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_dati    = rd_dati_q;
  assign bus.stall      = stall_q;
  assign bus.ld_busy    = ld_busy_q;
  assign bus.ld_pend_rd = ld_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32imc_3p_wb_arb.sv
// ============================================================================
// tb_rv32imc_3p_wb_arb : directed self-checking bench for the write-back arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rv32imc_3p_wb_arb;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  rv32imc_3p_wb_arb_if bus ();

  rv32imc_3p_wb_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout / expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid    = 1'b0;
    bus.alu_rd       = '0;
    bus.alu_dat      = '0;
    bus.ld_req_valid = 1'b0;
    bus.ld_rd        = '0;
    bus.ld_funct3    = '0;
    bus.ld_addr_lo   = '0;
    bus.ld_rsp_valid = 1'b0;
    bus.ld_rsp_dat   = '0;
    bus.md_valid     = 1'b0;
    bus.md_rd        = '0;
    bus.md_dat       = '0;
  endtask

  task automatic ld_req(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    bus.ld_req_valid = 1'b1;
    bus.ld_rd        = rd;
    bus.ld_funct3    = f3;
    bus.ld_addr_lo   = lo;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_we",     {31'd0, bus.c_rf_write}, 32'd0);
    chk("rst_addr",   {27'd0, bus.rd_addr},    32'd0);
    chk("rst_dati",   bus.rd_dati,             32'd0);
    chk("rst_stall",  {31'd0, bus.stall},      32'd0);
    chk("rst_busy",   {31'd0, bus.ld_busy},    32'd0);
    chk("rst_pendrd", {27'd0, bus.ld_pend_rd}, 32'd0);
    rst = 1'b0;
    tick();

    // ALU only
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_dat = 32'h1234;
    tick();
    idle_inputs();
    chk("alu_we",   {31'd0, bus.c_rf_write}, 32'd1);
    chk("alu_addr", {27'd0, bus.rd_addr},    32'd5);
    chk("alu_dati", bus.rd_dati,             32'h1234);
    tick();
    chk("idle_we",   {31'd0, bus.c_rf_write}, 32'd0);
    chk("idle_addr", {27'd0, bus.rd_addr},    32'd5);
    chk("idle_dati", bus.rd_dati,             32'h1234);

    // LB sign extension, one wait cycle before the response
    ld_req(5'd7, 3'b000, 2'd2);
    #1;
    chk("lb_busy_req", {31'd0, bus.ld_busy}, 32'd0);
    tick();
    idle_inputs();
    chk("lb_busy1", {31'd0, bus.ld_busy},    32'd1);
    chk("lb_pend",  {27'd0, bus.ld_pend_rd}, 32'd7);
    tick();
    chk("lb_busy2", {31'd0, bus.ld_busy},    32'd1);
    chk("lb_nowr",  {31'd0, bus.c_rf_write}, 32'd0);
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dat = 32'h0080_0000;
    tick();
    idle_inputs();
    chk("lb_we",   {31'd0, bus.c_rf_write}, 32'd1);
    chk("lb_addr", {27'd0, bus.rd_addr},    32'd7);
    chk("lb_dati", bus.rd_dati,             32'hFFFF_FF80);
    chk("lb_busy", {31'd0, bus.ld_busy},    32'd0);

    // LHU zero extension
    ld_req(5'd8, 3'b101, 2'd2);
    tick();
    idle_inputs();
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dat = 32'hBEEF_0000;
    tick();
    idle_inputs();
    chk("lhu_we",   {31'd0, bus.c_rf_write}, 32'd1);
    chk("lhu_addr", {27'd0, bus.rd_addr},    32'd8);
    chk("lhu_dati", bus.rd_dati,             32'h0000_BEEF);

    // Response with no load outstanding is ignored
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dat = 32'h1111_1111;
    tick();
    idle_inputs();
    chk("spur_we",   {31'd0, bus.c_rf_write}, 32'd0);
    chk("spur_dati", bus.rd_dati,             32'h0000_BEEF);

    // Load response and ALU collide in cycle n
    ld_req(5'd3, 3'b010, 2'd0);
    tick();
    idle_inputs();
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dat = 32'hCAFE_F00D;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_dat = 32'hA;
    tick();
    idle_inputs();
    chk("col1_we",    {31'd0, bus.c_rf_write}, 32'd1);
    chk("col1_addr",  {27'd0, bus.rd_addr},    32'd3);
    chk("col1_dati",  bus.rd_dati,             32'hCAFE_F00D);
    chk("col1_stall", {31'd0, bus.stall},      32'd1);
    tick();
    chk("col2_we",    {31'd0, bus.c_rf_write}, 32'd1);
    chk("col2_addr",  {27'd0, bus.rd_addr},    32'd4);
    chk("col2_dati",  bus.rd_dati,             32'hA);
    chk("col2_stall", {31'd0, bus.stall},      32'd1);
    tick();
    chk("col3_stall", {31'd0, bus.stall},      32'd0);
    chk("col3_we",    {31'd0, bus.c_rf_write}, 32'd0);

    // Mul/div starved by ALU, then acknowledged
    bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_dat = 32'h55;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_dat = 32'h1;
    #1;
    chk("md_ack0", {31'd0, bus.md_ack}, 32'd0);
    tick();
    chk("md_alu10", {27'd0, bus.rd_addr}, 32'd10);
    bus.alu_rd = 5'd11; bus.alu_dat = 32'h2;
    #1;
    chk("md_ack1", {31'd0, bus.md_ack}, 32'd0);
    tick();
    chk("md_alu11", {27'd0, bus.rd_addr}, 32'd11);
    bus.alu_valid = 1'b0;
    #1;
    chk("md_ack2", {31'd0, bus.md_ack}, 32'd1);
    tick();
    idle_inputs();
    #1;
    chk("md_ack3", {31'd0, bus.md_ack},     32'd0);
    chk("md_we",   {31'd0, bus.c_rf_write}, 32'd1);
    chk("md_addr", {27'd0, bus.rd_addr},    32'd9);
    chk("md_dati", bus.rd_dati,             32'h55);

    // x0 destination never writes
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_dat = 32'hFFFF;
    tick();
    idle_inputs();
    chk("x0_we", {31'd0, bus.c_rf_write}, 32'd0);

    // Back-to-back load plus collision, then reset with hold and load live
    ld_req(5'd12, 3'b010, 2'd0);
    tick();
    idle_inputs();
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dat = 32'h0000_00C0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_dat = 32'hD;
    ld_req(5'd14, 3'b000, 2'd0);
    tick();
    idle_inputs();
    chk("b2b_addr",  {27'd0, bus.rd_addr},    32'd12);
    chk("b2b_dati",  bus.rd_dati,             32'hC0);
    chk("b2b_busy",  {31'd0, bus.ld_busy},    32'd1);
    chk("b2b_pend",  {27'd0, bus.ld_pend_rd}, 32'd14);
    chk("b2b_stall", {31'd0, bus.stall},      32'd1);
    rst = 1'b1;
    #1;
    chk("arst_we",    {31'd0, bus.c_rf_write}, 32'd0);
    chk("arst_addr",  {27'd0, bus.rd_addr},    32'd0);
    chk("arst_dati",  bus.rd_dati,             32'd0);
    chk("arst_stall", {31'd0, bus.stall},      32'd0);
    chk("arst_busy",  {31'd0, bus.ld_busy},    32'd0);
    chk("arst_pend",  {27'd0, bus.ld_pend_rd}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_we",    {31'd0, bus.c_rf_write}, 32'd0);
    chk("post_stall", {31'd0, bus.stall},      32'd0);
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dat = 32'h7777_7777;
    tick();
    idle_inputs();
    chk("post_rsp_we", {31'd0, bus.c_rf_write}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
